mod_n_updown_counter: RTL and testbench

//   Synchronous, parametrised modulo-N up/down counter. Successor to the 4-bit ripple counter.

---
 rtl/mod_n_updown_counter.sv | 108 ++++++++++
 tb/tb_mod_n_updown_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mod_n_updown_counter.sv
// rtl/mod_n_updown_counter.sv - parametrised modulo-N up/down counter with load, tc and wrap
// Optional registered match comparator is built when COUNTER_MATCH_EN is defined.
module mod_n_updown_counter #(
   parameter int     WIDTH   = 4,
   parameter longint MODULUS = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_MATCH_EN
   input  logic [WIDTH-1:0] match_val,
   output logic             match,
`endif
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             tc,
   output logic             wrap
);

   generate
      if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
         $error("mod_n_updown_counter: WIDTH must be in 1..32");
      end
      if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
         $error("mod_n_updown_counter: MODULUS must be in 2..2**WIDTH");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             at_max;
   logic             at_zero;
   logic [WIDTH-1:0] load_clamped;

   assign at_max       = (q_q == MAX_Q);
   assign at_zero      = (q_q == '0);
   // Clamping against MAX_Q also covers MODULUS == 2**WIDTH, where no load value is out of range.
   assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;

   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (load) begin
         q_d = load_clamped;
      end else if (en) begin
         if (up_dn) begin
            if (at_max) begin
               q_d    = '0;
               wrap_d = 1'b1;
            end else begin
               q_d = q_q + ONE;
            end
         end else begin
            if (at_zero) begin
               q_d    = MAX_Q;
               wrap_d = 1'b1;
            end else begin
               q_d = q_q - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

`ifdef COUNTER_MATCH_EN
   logic match_q;
   logic match_d;

   // Compared against the next count so match rises together with q reaching match_val.
   always_comb begin
      match_d = (q_d == match_val);
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         match_q <= 1'b0;
      end else begin
         match_q <= match_d;
      end
   end

   assign match = match_q;
`endif

   assign q     = q_q;
   assign q_bar = ~q_q;
   assign wrap  = wrap_q;
   // Combinational so a cascaded stage sees it on the same edge it is needed.
   assign tc    = en & ((up_dn & at_max) | (~up_dn & at_zero));

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb/tb_mod_n_updown_counter.sv - directed self-checking bench for mod_n_updown_counter
module tb_mod_n_updown_counter;

   logic       clk;
   logic       clear;
   logic       en, up_dn, load;
   logic [3:0] load_val;
   logic [3:0] q, q_bar;
   logic       tc, wrap;

   logic       casc_clear, casc_en;
   logic [3:0] c0_q, c0_q_bar, c1_q, c1_q_bar;
   logic       c0_tc, c0_wrap, c1_tc, c1_wrap;

   logic       m2_en, m2_up;
   logic [0:0] m2_q, m2_q_bar;
   logic       m2_tc, m2_wrap;

`ifdef COUNTER_MATCH_EN
   logic [3:0] match_val;
   logic       match;
   logic       c0_match, c1_match, m2_match;
`endif

   int total = 0;
   int bad   = 0;
   int wraps;

   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u0 (
      .clk(clk), .clear(clear), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef COUNTER_MATCH_EN
      .match_val(match_val), .match(match),
`endif
      .q(q), .q_bar(q_bar), .tc(tc), .wrap(wrap)
   );

   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) c0 (
      .clk(clk), .clear(casc_clear), .en(casc_en), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
`ifdef COUNTER_MATCH_EN
      .match_val(4'd0), .match(c0_match),
`endif
      .q(c0_q), .q_bar(c0_q_bar), .tc(c0_tc), .wrap(c0_wrap)
   );

   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) c1 (
      .clk(clk), .clear(casc_clear), .en(c0_tc), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
`ifdef COUNTER_MATCH_EN
      .match_val(4'd0), .match(c1_match),
`endif
      .q(c1_q), .q_bar(c1_q_bar), .tc(c1_tc), .wrap(c1_wrap)
   );

   mod_n_updown_counter #(.WIDTH(1), .MODULUS(2)) m2 (
      .clk(clk), .clear(casc_clear), .en(m2_en), .up_dn(m2_up), .load(1'b0), .load_val(1'b0),
`ifdef COUNTER_MATCH_EN
      .match_val(1'b0), .match(m2_match),
`endif
      .q(m2_q), .q_bar(m2_q_bar), .tc(m2_tc), .wrap(m2_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_q;
      logic [3:0] lv_tab [4];
      logic [3:0] lq_tab [4];

      clear = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
      casc_clear = 1'b0; casc_en = 1'b0; m2_en = 1'b0; m2_up = 1'b1;
`ifdef COUNTER_MATCH_EN
      match_val = 4'd6;
`endif
      #2;
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_qbar", 32'(q_bar), 32'hF);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_tc_en0", 32'(tc), 32'd0);
      en = 1'b1; up_dn = 1'b0; #1;
      chk("rst_tc_down", 32'(tc), 32'd1);
      up_dn = 1'b1; #1;
      chk("rst_tc_up", 32'(tc), 32'd0);

      // Reach 7, then clear asynchronously mid-count.
      en = 1'b0; tick();
      clear = 1'b1; load = 1'b1; load_val = 4'd7; tick();
      chk("load7_q", 32'(q), 32'd7);
      load = 1'b0; en = 1'b1; up_dn = 1'b1;
      #2; clear = 1'b0; #1;
      chk("async_q", 32'(q), 32'd0);
      chk("async_qbar", 32'(q_bar), 32'hF);
      chk("async_wrap", 32'(wrap), 32'd0);
      tick();
      chk("held_q", 32'(q), 32'd0);

      // Up-count wrap over 12 edges.
      clear = 1'b1; #1;
      chk("up_start_tc", 32'(tc), 32'd0);
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_q = 4'(i % 10);
         chk($sformatf("up_q_%0d", i), 32'(q), 32'(exp_q));
         chk($sformatf("up_tc_%0d", i), 32'(tc), 32'(exp_q == 4'd9));
         chk($sformatf("up_wrap_%0d", i), 32'(wrap), 32'(i == 10));
      end

      // Down-count wrap from 2.
      en = 1'b0; load = 1'b1; load_val = 4'd2; tick();
      chk("dn_load_q", 32'(q), 32'd2);
      load = 1'b0; en = 1'b1; up_dn = 1'b0; #1;
      chk("dn_tc_at2", 32'(tc), 32'd0);
      tick(); chk("dn_q1", 32'(q), 32'd1);
      tick(); chk("dn_q0", 32'(q), 32'd0);
      chk("dn_tc0", 32'(tc), 32'd1);
      chk("dn_wrap_q0", 32'(wrap), 32'd0);
      tick(); chk("dn_q9", 32'(q), 32'd9);
      chk("dn_wrap_q9", 32'(wrap), 32'd1);
      chk("dn_tc_q9", 32'(tc), 32'd0);
      tick(); chk("dn_q8", 32'(q), 32'd8);
      chk("dn_wrap_q8", 32'(wrap), 32'd0);

      // Load priority and clamp.
      load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 4'd13; tick();
      chk("clamp13_q", 32'(q), 32'd9);
      chk("clamp13_wrap", 32'(wrap), 32'd0);
      load_val = 4'd5; tick();
      chk("load5_q", 32'(q), 32'd5);
      chk("load5_wrap", 32'(wrap), 32'd0);
      lv_tab = '{4'd9, 4'd10, 4'd15, 4'd0};
      lq_tab = '{4'd9, 4'd9, 4'd9, 4'd0};
      for (int i = 0; i < 4; i++) begin
         load_val = lv_tab[i]; tick();
         chk($sformatf("load_tab_%0d", i), 32'(q), 32'(lq_tab[i]));
      end
      load = 1'b0; en = 1'b0; load_val = 4'd3; tick();
      chk("hold_q", 32'(q), 32'd0);
      chk("hold_wrap", 32'(wrap), 32'd0);

`ifdef COUNTER_MATCH_EN
      match_val = 4'd6; en = 1'b1; up_dn = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("match_%0d", i), 32'(match), 32'(i == 6));
      end
      en = 1'b0;
      tick(); chk("match_hold1", 32'(match), 32'd1);
      tick(); chk("match_hold2", 32'(match), 32'd1);
`endif

      // Two-stage decade cascade.
      casc_clear = 1'b1; casc_en = 1'b1; wraps = 0;
      for (int i = 1; i <= 101; i++) begin
         tick();
         chk($sformatf("casc_%0d", i), 32'(c1_q) * 10 + 32'(c0_q), 32'(i % 100));
         if (c1_wrap) wraps++;
         if (i == 99) begin
            chk("casc_tc0_99", 32'(c0_tc), 32'd1);
            chk("casc_tc1_99", 32'(c1_tc), 32'd1);
         end
      end
      chk("casc_wraps", 32'(wraps), 32'd1);
      casc_en = 1'b0;

      // MODULUS=2: up wraps every other edge, alternating direction wraps every edge.
      m2_en = 1'b1; m2_up = 1'b1;
      tick(); chk("m2_up_q1", 32'(m2_q), 32'd1); chk("m2_up_w1", 32'(m2_wrap), 32'd0);
      tick(); chk("m2_up_q0", 32'(m2_q), 32'd0); chk("m2_up_w0", 32'(m2_wrap), 32'd1);
      m2_up = 1'b0;
      tick(); chk("m2_alt_q1", 32'(m2_q), 32'd1); chk("m2_alt_w1", 32'(m2_wrap), 32'd1);
      m2_up = 1'b1;
      tick(); chk("m2_alt_q0", 32'(m2_q), 32'd0); chk("m2_alt_w0", 32'(m2_wrap), 32'd1);
      m2_up = 1'b0;
      tick(); chk("m2_alt_q1b", 32'(m2_q), 32'd1); chk("m2_alt_w1b", 32'(m2_wrap), 32'd1);
      m2_en = 1'b0;
      tick(); chk("m2_hold_w", 32'(m2_wrap), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
